polynomial_finder_scheduler: RTL and testbench

Shares one `polynomial_finder` instance between `NUM_CHANNELS` photodiode decode channels. Each channel presents one job: two consecutive decoded 17-bit LFSR words and their 24-bit timestamps. The scheduler grants jobs round-robin, latches the operands, and drives the finder's `enable`/`ready` handshake. It returns the polynomial and iteration number tagged with the channel index, and aborts a job if the finder does not finish in time. It sits between the per-channel decoders and the pose/timing back-end.

---
 rtl/polynomial_finder_pkg.sv | 21 ++
 rtl/polynomial_finder_scheduler_rr_arbiter.sv | 30 +++
 rtl/polynomial_finder_scheduler.sv | 146 ++++++++++++++
 tb/tb_polynomial_finder_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polynomial_finder_pkg.sv
// Shared widths, FSM states and the latched job record for the
// polynomial finder scheduler.
package polynomial_finder_pkg;

    localparam int TS_W   = 24;
    localparam int LFSR_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RELEASE
    } state_t;

    typedef struct packed {
        logic [TS_W-1:0]   ts0;
        logic [TS_W-1:0]   ts1;
        logic [LFSR_W-1:0] data0;
        logic [LFSR_W-1:0] data1;
    } job_t;

endpackage

// File: rtl/polynomial_finder_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; returns
// both the one-hot grant and its index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int c;

    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = IW'(c);
            end
        end
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/polynomial_finder_scheduler.sv
// Time-shares one polynomial_finder between NUM_CHANNELS decode channels:
// round-robin grant, operand latch, enable/ready handshake, timeout abort.
module polynomial_finder_scheduler
    import polynomial_finder_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int TIMEOUT_CYCLES = 140000,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                              clk_96MHz,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           req_valid,
    input  logic [TS_W*NUM_CHANNELS-1:0]      req_ts_last_data,
    input  logic [TS_W*NUM_CHANNELS-1:0]      req_ts_last_data1,
    input  logic [LFSR_W*NUM_CHANNELS-1:0]    req_decoded_data,
    input  logic [LFSR_W*NUM_CHANNELS-1:0]    req_decoded_data1,
    output logic [NUM_CHANNELS-1:0]           req_ack,
    output logic [TS_W-1:0]                   pf_ts_last_data,
    output logic [TS_W-1:0]                   pf_ts_last_data1,
    output logic [LFSR_W-1:0]                 pf_decoded_data,
    output logic [LFSR_W-1:0]                 pf_decoded_data1,
    output logic                              pf_enable,
    input  logic [LFSR_W-1:0]                 pf_polynomial,
    input  logic [LFSR_W-1:0]                 pf_iteration_number,
    input  logic                              pf_ready,
    output logic                              res_valid,
    output logic [$clog2(NUM_CHANNELS)-1:0]   res_channel,
    output logic [LFSR_W-1:0]                 res_polynomial,
    output logic [LFSR_W-1:0]                 res_iteration_number,
    output logic                              res_timeout,
    output logic                              busy
);

    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

    job_t                    jobs [NUM_CHANNELS];
    job_t                    sel_job;
    state_t                  state;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         job_ch;
    logic [CNT_W-1:0]        run_cnt;
    logic [REL_W-1:0]        rel_cnt;
    logic [NUM_CHANNELS-1:0] grant;
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_any;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
        assign jobs[i] = '{
            ts0:   req_ts_last_data [TS_W*i   +: TS_W],
            ts1:   req_ts_last_data1[TS_W*i   +: TS_W],
            data0: req_decoded_data [LFSR_W*i +: LFSR_W],
            data1: req_decoded_data1[LFSR_W*i +: LFSR_W]
        };
    end

    rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign sel_job = jobs[grant_idx];

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            job_ch               <= '0;
            run_cnt              <= '0;
            rel_cnt              <= '0;
            req_ack              <= '0;
            pf_ts_last_data      <= '0;
            pf_ts_last_data1     <= '0;
            pf_decoded_data      <= '0;
            pf_decoded_data1     <= '0;
            pf_enable            <= 1'b0;
            res_valid            <= 1'b0;
            res_channel          <= '0;
            res_polynomial       <= '0;
            res_iteration_number <= '0;
            res_timeout          <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            req_ack   <= '0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        req_ack          <= grant;
                        job_ch           <= grant_idx;
                        pf_ts_last_data  <= sel_job.ts0;
                        pf_ts_last_data1 <= sel_job.ts1;
                        pf_decoded_data  <= sel_job.data0;
                        pf_decoded_data1 <= sel_job.data1;
                        rr_ptr           <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
                        run_cnt          <= '0;
                        pf_enable        <= 1'b1;
                        busy             <= 1'b1;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    // Ready seen on the first RUN cycle belongs to the previous job.
                    if (run_cnt != '0 && pf_ready) begin
                        res_valid            <= 1'b1;
                        res_channel          <= job_ch;
                        res_polynomial       <= pf_polynomial;
                        res_iteration_number <= pf_iteration_number;
                        res_timeout          <= 1'b0;
                        pf_enable            <= 1'b0;
                        rel_cnt              <= '0;
                        state                <= RELEASE;
                    end else if (run_cnt == CNT_MAX) begin
                        res_valid            <= 1'b1;
                        res_channel          <= job_ch;
                        res_polynomial       <= '0;
                        res_iteration_number <= '0;
                        res_timeout          <= 1'b1;
                        pf_enable            <= 1'b0;
                        rel_cnt              <= '0;
                        state                <= RELEASE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polynomial_finder_scheduler.sv
// Bench for polynomial_finder_scheduler with a behavioural finder stub and a
// round-robin / latency reference model.
module tb_polynomial_finder_scheduler;

    localparam int NC = 4;
    localparam int T  = 50;
    localparam int R  = 2;
    localparam logic [16:0] STALE_POLY = 17'h1A5A5;
    localparam logic [16:0] STALE_ITER = 17'h1BEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] req_valid;
    logic [24*NC-1:0] req_ts_last_data, req_ts_last_data1;
    logic [17*NC-1:0] req_decoded_data, req_decoded_data1;
    logic [NC-1:0] req_ack;
    logic [23:0]   pf_ts_last_data, pf_ts_last_data1;
    logic [16:0]   pf_decoded_data, pf_decoded_data1;
    logic          pf_enable;
    logic [16:0]   pf_polynomial, pf_iteration_number;
    logic          pf_ready;
    logic          res_valid;
    logic [1:0]    res_channel;
    logic [16:0]   res_polynomial, res_iteration_number;
    logic          res_timeout;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_ptr = 0;

    polynomial_finder_scheduler #(
        .NUM_CHANNELS(NC), .TIMEOUT_CYCLES(T), .RELEASE_CYCLES(R)
    ) dut (
        .clk_96MHz(clk), .reset(reset), .req_valid(req_valid),
        .req_ts_last_data(req_ts_last_data), .req_ts_last_data1(req_ts_last_data1),
        .req_decoded_data(req_decoded_data), .req_decoded_data1(req_decoded_data1),
        .req_ack(req_ack),
        .pf_ts_last_data(pf_ts_last_data), .pf_ts_last_data1(pf_ts_last_data1),
        .pf_decoded_data(pf_decoded_data), .pf_decoded_data1(pf_decoded_data1),
        .pf_enable(pf_enable), .pf_polynomial(pf_polynomial),
        .pf_iteration_number(pf_iteration_number), .pf_ready(pf_ready),
        .res_valid(res_valid), .res_channel(res_channel),
        .res_polynomial(res_polynomial), .res_iteration_number(res_iteration_number),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Finder stub: ready stub_n cycles after enable rises (0 = never);
    // optionally holds a stale ready while enable is low.
    int          stub_n = 10;
    bit          stub_stale = 1'b0;
    bit          stub_fixed = 1'b1;
    logic [16:0] stub_poly = '0, stub_iter = '0;
    int          en_cnt = 0;
    logic        stub_hit = 1'b0, stale_r = 1'b0;

    always @(posedge clk) begin
        if (!pf_enable) begin
            en_cnt   <= 0;
            stub_hit <= 1'b0;
            stale_r  <= stub_stale;
        end else begin
            en_cnt  <= en_cnt + 1;
            stale_r <= 1'b0;
            if (stub_n != 0 && en_cnt + 1 >= stub_n) stub_hit <= 1'b1;
        end
    end

    assign pf_ready = stub_hit | stale_r;
    assign pf_polynomial = stub_hit ? (stub_fixed ? stub_poly : pf_decoded_data ^ pf_decoded_data1)
                                    : STALE_POLY;
    assign pf_iteration_number = stub_hit ? (stub_fixed ? stub_iter
                                                        : pf_ts_last_data[16:0] + pf_ts_last_data1[16:0])
                                          : STALE_ITER;

    typedef struct {
        int          ch;
        logic [16:0] p;
        logic [16:0] it;
    } exp_t;
    exp_t exp_q[$];

    function automatic int rr_pick(input int ptr, input logic [NC-1:0] v);
        for (int k = 0; k < NC; k++)
            if (v[(ptr + k) % NC]) return (ptr + k) % NC;
        return -1;
    endfunction

    function automatic logic [23:0] ts0_of(input int ch); return req_ts_last_data[24*ch +: 24]; endfunction
    function automatic logic [23:0] ts1_of(input int ch); return req_ts_last_data1[24*ch +: 24]; endfunction
    function automatic logic [16:0] d0_of(input int ch);  return req_decoded_data[17*ch +: 17]; endfunction
    function automatic logic [16:0] d1_of(input int ch);  return req_decoded_data1[17*ch +: 17]; endfunction
    function automatic logic [16:0] model_poly(input int ch); return d0_of(ch) ^ d1_of(ch); endfunction
    function automatic logic [16:0] model_iter(input int ch); return ts0_of(ch)[16:0] + ts1_of(ch)[16:0]; endfunction

    task automatic set_job(input int ch, input logic [23:0] t0, input logic [23:0] t1,
                           input logic [16:0] d0, input logic [16:0] d1);
        req_ts_last_data[24*ch +: 24]  = t0;
        req_ts_last_data1[24*ch +: 24] = t1;
        req_decoded_data[17*ch +: 17]  = d0;
        req_decoded_data1[17*ch +: 17] = d1;
    endtask

    task automatic rand_job(input int ch);
        set_job(ch, 24'($urandom), 24'($urandom), 17'($urandom), 17'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        stub_stale = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic wait_ack(input int budget, output int at, output logic [NC-1:0] vec);
        at = -1;
        vec = '0;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (req_ack !== '0) begin at = cyc; vec = req_ack; end
        end
    endtask

    task automatic wait_res(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) at = cyc;
        end
    endtask

    // Cycles spent busy with enable dropped, starting at the result cycle.
    task automatic release_len(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1 && pf_enable === 1'b0) n++;
            else break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ack !== '0) begin errors++; $display("FAIL reset_ack got=%b want=0", req_ack); end
        checks++; if (pf_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b want=0", pf_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if ({res_valid, res_timeout, res_channel, res_polynomial, res_iteration_number} !== '0) begin
            errors++; $display("FAIL reset_res got=%h want=0", {res_valid, res_timeout, res_channel, res_polynomial, res_iteration_number});
        end
        checks++; if ({pf_ts_last_data, pf_ts_last_data1, pf_decoded_data, pf_decoded_data1} !== '0) begin
            errors++; $display("FAIL reset_pf got=%h want=0", {pf_ts_last_data, pf_ts_last_data1, pf_decoded_data, pf_decoded_data1});
        end
        reset = 1'b0;
        exp_ptr = 0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || req_ack !== '0) begin
            errors++; $display("FAIL idle_no_req got busy=%b ack=%b want 0/0", busy, req_ack);
        end
    endtask

    task automatic test_single_job();
        int ack_at, res_at, rl;
        stub_n = 10; stub_fixed = 1'b1; stub_poly = 17'h0D0A1; stub_iter = 17'h00F3C;
        set_job(0, 24'h9C586A, 24'hA3B827, 17'h149D0, 17'h1C8F9);
        req_valid = 4'b0001;
        @(negedge clk);
        ack_at = cyc;
        checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b want=0001", req_ack); end
        checks++; if ({pf_ts_last_data, pf_ts_last_data1, pf_decoded_data, pf_decoded_data1} !==
                      {24'h9C586A, 24'hA3B827, 17'h149D0, 17'h1C8F9}) begin
            errors++; $display("FAIL single_operands got=%h/%h/%h/%h want=9c586a/a3b827/149d0/1c8f9",
                               pf_ts_last_data, pf_ts_last_data1, pf_decoded_data, pf_decoded_data1);
        end
        checks++; if (pf_enable !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_enable got en=%b busy=%b want 1/1", pf_enable, busy);
        end
        req_valid = '0;
        exp_ptr = 1;
        wait_res(200, res_at);
        checks++; if (res_at < 0 || res_at - ack_at != stub_n + 1) begin
            errors++; $display("FAIL single_latency got=%0d want=%0d", res_at < 0 ? -1 : res_at - ack_at, stub_n + 1);
        end
        checks++; if ({res_channel, res_polynomial, res_iteration_number, res_timeout} !==
                      {2'd0, 17'h0D0A1, 17'h00F3C, 1'b0}) begin
            errors++; $display("FAIL single_result got ch=%0d p=%h it=%h to=%b want ch=0 p=0d0a1 it=00f3c to=0",
                               res_channel, res_polynomial, res_iteration_number, res_timeout);
        end
        release_len(rl);
        checks++; if (rl != R) begin errors++; $display("FAIL single_release got=%0d want=%0d", rl, R); end
    endtask

    task automatic test_fairness();
        int nacks = 0, nres = 0, extra = 0, ch;
        exp_t e;
        do_reset();
        stub_fixed = 1'b0;
        stub_n = $urandom_range(1, 6);
        exp_q.delete();
        for (int i = 0; i < NC; i++) rand_job(i);
        req_valid = '1;
        for (int c = 0; c < 400 && nres < 5; c++) begin
            @(negedge clk);
            if (req_ack !== '0) begin
                ch = rr_pick(exp_ptr, req_valid);
                checks++; if (!$onehot(req_ack)) begin errors++; $display("FAIL fair_onehot got=%b", req_ack); end
                checks++; if (req_ack !== 4'(1 << ch)) begin
                    errors++; $display("FAIL fair_order got=%b want=%b", req_ack, 4'(1 << ch));
                end
                checks++; if ({pf_ts_last_data, pf_ts_last_data1, pf_decoded_data, pf_decoded_data1} !==
                              {ts0_of(ch), ts1_of(ch), d0_of(ch), d1_of(ch)}) begin
                    errors++; $display("FAIL fair_operands ch=%0d got=%h want=%h", ch,
                        {pf_ts_last_data, pf_ts_last_data1, pf_decoded_data, pf_decoded_data1},
                        {ts0_of(ch), ts1_of(ch), d0_of(ch), d1_of(ch)});
                end
                exp_q.push_back('{ch: ch, p: model_poly(ch), it: model_iter(ch)});
                exp_ptr = (ch + 1) % NC;
                nacks++;
                if (nacks == 5) req_valid = '0;
                else rand_job(ch);
            end
            if (res_valid === 1'b1) begin
                nres++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL fair_extra_result ch=%0d", res_channel);
                end else begin
                    e = exp_q.pop_front();
                    if ({res_channel, res_polynomial, res_iteration_number, res_timeout} !==
                        {2'(e.ch), e.p, e.it, 1'b0}) begin
                        errors++; $display("FAIL fair_result got ch=%0d p=%h it=%h to=%b want ch=%0d p=%h it=%h to=0",
                            res_channel, res_polynomial, res_iteration_number, res_timeout, e.ch, e.p, e.it);
                    end
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) extra++;
        end
        checks++; if (nres != 5 || nacks != 5 || extra != 0) begin
            errors++; $display("FAIL fair_count got acks=%0d res=%0d extra=%0d want 5/5/0", nacks, nres, extra);
        end
    endtask

    task automatic test_timeout();
        int ch, ack_at, res_at, rl;
        logic [NC-1:0] vec;
        do_reset();
        stub_n = 0;
        ch = $urandom_range(0, NC - 1);
        rand_job(ch);
        req_valid = 4'(1 << ch);
        wait_ack(5, ack_at, vec);
        checks++; if (vec !== 4'(1 << ch)) begin errors++; $display("FAIL to_ack got=%b want=%b", vec, 4'(1 << ch)); end
        req_valid = '0;
        wait_res(T + 20, res_at);
        checks++; if (res_at < 0 || res_at - ack_at != T + 1) begin
            errors++; $display("FAIL to_latency got=%0d want=%0d", res_at < 0 ? -1 : res_at - ack_at, T + 1);
        end
        checks++; if ({res_channel, res_polynomial, res_iteration_number, res_timeout} !==
                      {2'(ch), 17'd0, 17'd0, 1'b1}) begin
            errors++; $display("FAIL to_result got ch=%0d p=%h it=%h to=%b want ch=%0d p=0 it=0 to=1",
                               res_channel, res_polynomial, res_iteration_number, res_timeout, ch);
        end
        release_len(rl);
        checks++; if (rl != R) begin errors++; $display("FAIL to_release got=%0d want=%0d", rl, R); end
        stub_n = 10;
    endtask

    task automatic test_stale_ready();
        int ch, ack_at, res_at;
        logic [NC-1:0] vec;
        do_reset();
        stub_fixed = 1'b1; stub_n = 5; stub_stale = 1'b1;
        stub_poly = {1'b0, 16'($urandom)};
        stub_iter = {1'b0, 16'($urandom)};
        ch = $urandom_range(0, NC - 1);
        rand_job(ch);
        @(negedge clk);
        req_valid = 4'(1 << ch);
        wait_ack(5, ack_at, vec);
        req_valid = '0;
        wait_res(40, res_at);
        checks++; if (res_at < 0 || res_at - ack_at != 6) begin
            errors++; $display("FAIL stale_latency got=%0d want=6", res_at < 0 ? -1 : res_at - ack_at);
        end
        checks++; if ({res_polynomial, res_iteration_number, res_timeout} !== {stub_poly, stub_iter, 1'b0}) begin
            errors++; $display("FAIL stale_result got p=%h it=%h to=%b want p=%h it=%h to=0",
                               res_polynomial, res_iteration_number, res_timeout, stub_poly, stub_iter);
        end
        stub_stale = 1'b0;
        repeat (R + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int ack_at, res_at, stray = 0, ch;
        logic [NC-1:0] vec;
        do_reset();
        stub_fixed = 1'b0; stub_n = 10;
        rand_job(1); rand_job(3);
        req_valid = 4'b0010;
        wait_ack(5, ack_at, vec);
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (pf_enable !== 1'b0 || busy !== 1'b0 || req_ack !== '0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL rst_run_ctrl got en=%b busy=%b ack=%b rv=%b want all 0", pf_enable, busy, req_ack, res_valid);
        end
        checks++; if ({pf_ts_last_data, pf_ts_last_data1, pf_decoded_data, pf_decoded_data1,
                       res_channel, res_polynomial, res_iteration_number, res_timeout} !== '0) begin
            errors++; $display("FAIL rst_run_data got nonzero outputs want 0");
        end
        reset = 1'b0;
        exp_ptr = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_run_stray got=%0d want=0", stray); end
        req_valid = 4'b1010;
        ch = rr_pick(exp_ptr, req_valid);
        wait_ack(5, ack_at, vec);
        checks++; if (vec !== 4'(1 << ch)) begin errors++; $display("FAIL rst_run_ptr got=%b want=%b", vec, 4'(1 << ch)); end
        req_valid = '0;
        wait_res(40, res_at);
        checks++; if (res_at < 0 || {res_channel, res_polynomial, res_iteration_number} !==
                      {2'(ch), model_poly(ch), model_iter(ch)}) begin
            errors++; $display("FAIL rst_run_result got ch=%0d p=%h it=%h want ch=%0d p=%h it=%h",
                               res_channel, res_polynomial, res_iteration_number, ch, model_poly(ch), model_iter(ch));
        end
        repeat (R + 2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int a, b, c1, c2, ack1, ack2, res1, rl;
        logic [NC-1:0] vec;
        do_reset();
        stub_fixed = 1'b0;
        stub_n = $urandom_range(1, 6);
        a = $urandom_range(0, NC - 1);
        b = (a + $urandom_range(1, NC - 1)) % NC;
        rand_job(a); rand_job(b);
        req_valid = 4'(1 << a) | 4'(1 << b);
        c1 = rr_pick(exp_ptr, req_valid);
        c2 = (c1 == a) ? b : a;
        wait_ack(5, ack1, vec);
        checks++; if (vec !== 4'(1 << c1)) begin errors++; $display("FAIL b2b_first got=%b want=%b", vec, 4'(1 << c1)); end
        req_valid[c1] = 1'b0;
        wait_res(40, res1);
        checks++; if (res1 < 0 || {res_channel, res_polynomial} !== {2'(c1), model_poly(c1)}) begin
            errors++; $display("FAIL b2b_res1 got ch=%0d p=%h want ch=%0d p=%h", res_channel, res_polynomial, c1, model_poly(c1));
        end
        release_len(rl);
        checks++; if (rl != R) begin errors++; $display("FAIL b2b_release got=%0d want=%0d", rl, R); end
        wait_ack(10, ack2, vec);
        checks++; if (vec !== 4'(1 << c2)) begin errors++; $display("FAIL b2b_second got=%b want=%b", vec, 4'(1 << c2)); end
        checks++; if (ack2 - ack1 != stub_n + R + 2) begin
            errors++; $display("FAIL b2b_spacing got=%0d want=%0d", ack2 - ack1, stub_n + R + 2);
        end
        req_valid = '0;
        wait_res(40, res1);
        checks++; if (res1 < 0 || {res_channel, res_iteration_number} !== {2'(c2), model_iter(c2)}) begin
            errors++; $display("FAIL b2b_res2 got ch=%0d it=%h want ch=%0d it=%h", res_channel, res_iteration_number, c2, model_iter(c2));
        end
        repeat (R + 2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_ts_last_data = '0; req_ts_last_data1 = '0;
        req_decoded_data = '0; req_decoded_data1 = '0;
        @(negedge clk);
        test_reset();
        test_single_job();
        test_fairness();
        test_timeout();
        test_stale_ready();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
